// File: rtl/ldpc_info_framer_if.sv
// Stream handshake bundle shared by the word-wide input and the bit-serial output of the framer.
// The master drives data/valid/last; the slave answers with ready.
interface ldpc_info_framer_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ldpc_info_framer.sv
// Serialises user info words MSB-first into exactly K info bits per LDPC block, truncating
// over-long blocks and zero-filling short ones.
module ldpc_info_framer #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            mode,
  ldpc_info_framer_if.slave     s_axis,
  ldpc_info_framer_if.master    m_axis,
  output logic                  busy,
  output logic                  pad_active,
  output logic                  len_err,
  output logic                  mode_err,
  output logic [CNT_W-1:0]      blk_cnt
);

  localparam int unsigned BlW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StPad} state_e;

  state_e            st_q, st_d;
  logic [IN_W-1:0]   sr_q, sr_d;
  logic [BlW-1:0]    left_q, left_d;
  logic              last_q, last_d;
  logic [14:0]       km1_q, km1_d;
  logic [14:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]  blk_q, blk_d;
  logic              len_err_q, len_err_d;
  logic              mode_err_q, mode_err_d;

  logic m_valid, m_hs, s_ready, s_hs, bit_k, word_end;

  // Reserved codes fall back to the 1024-bit code.
  function automatic logic [14:0] k_minus1(input logic [2:0] m);
    logic [14:0] k;
    case (m)
      3'd0:    k = 15'd7153;
      3'd1:    k = 15'd7135;
      3'd3:    k = 15'd4095;
      3'd4:    k = 15'd16383;
      default: k = 15'd1023;
    endcase
    return k;
  endfunction

  always_comb begin
    m_valid  = ((st_q == StShift) && (left_q != '0)) || (st_q == StPad);
    bit_k    = (cnt_q == km1_q);
    m_hs     = m_valid && m_axis.tready;
    word_end = (left_q == BlW'(1));

    // In SHIFT, ready only when the word is empty or its final non-K bit leaves this cycle.
    s_ready = 1'b0;
    unique case (st_q)
      StIdle:  s_ready = 1'b1;
      StShift: s_ready = (left_q == '0) || (m_hs && word_end && !last_q && !bit_k);
      StPad:   s_ready = 1'b0;
      default: s_ready = 1'b0;
    endcase
    s_ready = s_ready && !rst;
    s_hs    = s_axis.tvalid && s_ready;

    s_axis.tready = s_ready;
    m_axis.tvalid = m_valid;
    m_axis.tdata  = (st_q == StShift) ? sr_q[IN_W-1] : 1'b0;
    m_axis.tlast  = m_valid && bit_k;
  end

  always_comb begin
    st_d       = st_q;
    sr_d       = sr_q;
    left_d     = left_q;
    last_d     = last_q;
    km1_d      = km1_q;
    cnt_d      = cnt_q;
    blk_d      = blk_q;
    len_err_d  = 1'b0;
    mode_err_d = 1'b0;

    unique case (st_q)
      StIdle: begin
        if (s_hs) begin
          st_d       = StShift;
          sr_d       = s_axis.tdata;
          left_d     = BlW'(IN_W);
          last_d     = s_axis.tlast;
          km1_d      = k_minus1(mode);
          mode_err_d = (mode > 3'd4);
        end
      end
      StShift: begin
        if (m_hs) begin
          cnt_d  = cnt_q + 15'd1;
          sr_d   = sr_q << 1;
          left_d = left_q - BlW'(1);
          if (word_end && last_q) st_d = StPad;
        end
        if (s_hs) begin
          sr_d   = s_axis.tdata;
          left_d = BlW'(IN_W);
          last_d = s_axis.tlast;
        end
      end
      StPad: begin
        if (m_hs) cnt_d = cnt_q + 15'd1;
      end
      default: st_d = StIdle;
    endcase

    // Bit K closes the block; any unsent bits of the current word are dropped.
    if (m_hs && bit_k) begin
      st_d      = StIdle;
      cnt_d     = '0;
      left_d    = '0;
      blk_d     = blk_q + CNT_W'(1);
      len_err_d = (st_q == StShift) && !last_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= StIdle;
      sr_q       <= '0;
      left_q     <= '0;
      last_q     <= 1'b0;
      km1_q      <= 15'd1023;
      cnt_q      <= '0;
      blk_q      <= '0;
      len_err_q  <= 1'b0;
      mode_err_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      sr_q       <= sr_d;
      left_q     <= left_d;
      last_q     <= last_d;
      km1_q      <= km1_d;
      cnt_q      <= cnt_d;
      blk_q      <= blk_d;
      len_err_q  <= len_err_d;
      mode_err_q <= mode_err_d;
    end
  end

  assign busy       = (st_q != StIdle);
  assign pad_active = (st_q == StPad);
  assign len_err    = len_err_q;
  assign mode_err   = mode_err_q;
  assign blk_cnt    = blk_q;

endmodule
